// File: rtl/dec_operand_align.sv
// rtl/dec_operand_align.sv - exponent ordering and digit-serial right-shift alignment ahead of the BCD adder
module dec_operand_align #(
    parameter int DIGITS = 7,
    parameter int EW     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a_man,
    input  logic [EW-1:0]       a_exp,
    input  logic [4*DIGITS-1:0] b_man,
    input  logic [EW-1:0]       b_exp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] big_man,
    output logic [4*DIGITS-1:0] small_man,
    output logic [EW-1:0]       res_exp,
    output logic [3:0]          guard,
    output logic                sticky,
    output logic                swap
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            a_ge_b;
    logic [EW-1:0]   diff;
    logic            diff_in_range;
    logic [W-1:0]    big_sel;
    logic [W-1:0]    small_sel;
    logic            accept;

    assign a_ge_b        = (a_exp >= b_exp);
    assign diff          = a_ge_b ? (a_exp - b_exp) : (b_exp - a_exp);
    assign diff_in_range = (diff <= EW'(DIGITS));
    assign big_sel       = a_ge_b ? a_man : b_man;
    assign small_sel     = a_ge_b ? b_man : a_man;
    assign accept        = (state == IDLE) && in_valid;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (diff != '0 && diff_in_range) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            big_man   <= '0;
            small_man <= '0;
            res_exp   <= '0;
            guard     <= '0;
            sticky    <= 1'b0;
            swap      <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            big_man <= big_sel;
            res_exp <= a_ge_b ? a_exp : b_exp;
            swap    <= !a_ge_b;
            guard   <= '0;
            cnt     <= CW'(diff);
            // Beyond DIGITS every digit falls out, so only the sticky summary survives.
            if (diff_in_range) begin
                small_man <= small_sel;
                sticky    <= 1'b0;
            end else begin
                small_man <= '0;
                sticky    <= (small_sel != '0);
            end
        end else if (state == SHIFT) begin
            sticky    <= sticky | (guard != 4'd0);
            guard     <= small_man[3:0];
            small_man <= {4'd0, small_man[W-1:4]};
            cnt       <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_dec_operand_align.sv
// tb/tb_dec_operand_align.sv - randomized self-checking bench for dec_operand_align
module tb_dec_operand_align;
    localparam int DIGITS = 7;
    localparam int EW     = 8;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_man = '0;
    logic [EW-1:0] a_exp = '0;
    logic [W-1:0]  b_man = '0;
    logic [EW-1:0] b_exp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  big_man;
    logic [W-1:0]  small_man;
    logic [EW-1:0] res_exp;
    logic [3:0]    guard;
    logic          sticky;
    logic          swap;

    int errors = 0;
    int checks = 0;

    dec_operand_align #(.DIGITS(DIGITS), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_man(a_man), .a_exp(a_exp), .b_man(b_man), .b_exp(b_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_man(big_man), .small_man(small_man), .res_exp(res_exp),
        .guard(guard), .sticky(sticky), .swap(swap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: alignment as a division by 10^d on a digit array.
    task automatic model(input logic [W-1:0] am, input int ae, input logic [W-1:0] bm, input int be,
                         output logic [W-1:0] e_big, output logic [W-1:0] e_small, output int e_exp,
                         output logic [3:0] e_guard, output logic e_sticky, output logic e_swap,
                         output int e_lat);
        int d;
        logic [3:0] dig [DIGITS];
        logic [W-1:0] sm;
        if (ae >= be) begin
            e_big = am; sm = bm; e_exp = ae; e_swap = 1'b0; d = ae - be;
        end else begin
            e_big = bm; sm = am; e_exp = be; e_swap = 1'b1; d = be - ae;
        end
        for (int i = 0; i < DIGITS; i++) dig[i] = sm[4*i +: 4];
        e_small = '0; e_guard = 4'd0; e_sticky = 1'b0; e_lat = 1;
        if (d == 0) begin
            e_small = sm;
        end else if (d <= DIGITS) begin
            for (int i = d; i < DIGITS; i++) e_small[4*(i-d) +: 4] = dig[i];
            e_guard = dig[d-1];
            for (int i = 0; i < d - 1; i++) if (dig[i] != 4'd0) e_sticky = 1'b1;
            e_lat = 1 + d;
        end else begin
            e_sticky = (sm != '0);
        end
    endtask

    task automatic check_outs(input string tag, input logic [W-1:0] e_big, input logic [W-1:0] e_small,
                              input int e_exp, input logic [3:0] e_guard, input logic e_sticky,
                              input logic e_swap);
        check({tag, ".big"}, 64'(big_man), 64'(e_big));
        check({tag, ".small"}, 64'(small_man), 64'(e_small));
        check({tag, ".exp"}, 64'(res_exp), 64'(e_exp));
        check({tag, ".guard"}, 64'(guard), 64'(e_guard));
        check({tag, ".sticky"}, 64'(sticky), 64'(e_sticky));
        check({tag, ".swap"}, 64'(swap), 64'(e_swap));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] am, input int ae,
                          input logic [W-1:0] bm, input int be, input int hold, input logic pend);
        logic [W-1:0] e_big, e_small;
        int e_exp, e_lat, lat;
        logic [3:0] e_guard;
        logic e_sticky, e_swap;
        model(am, ae, bm, be, e_big, e_small, e_exp, e_guard, e_sticky, e_swap, e_lat);
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a_man = am; a_exp = EW'(ae); b_man = bm; b_exp = EW'(be); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_man = ~am; b_man = ~bm;
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(e_lat));
        check_outs(tag, e_big, e_small, e_exp, e_guard, e_sticky, e_swap);
        if (pend) begin
            in_valid = 1'b1; a_man = '1; b_man = '1; a_exp = 8'd1; b_exp = 8'd200;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
            check_outs({tag, ".hold"}, e_big, e_small, e_exp, e_guard, e_sticky, e_swap);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check_outs("rst", '0, '0, 0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("align", 28'h0001234, 5, 28'h0000567, 3, 0, 1'b0);
        run_op("swap", 28'h1000000, 2, 28'h2000000, 3, 0, 1'b0);
        run_op("equal", 28'h0000099, 9, 28'h0000001, 9, 0, 1'b0);
        run_op("full7", 28'h1111111, 10, 28'h9000000, 3, 0, 1'b0);
        run_op("shortcut", 28'h0000042, 20, 28'h0000001, 4, 0, 1'b0);
        run_op("shortcut0", 28'h0000042, 20, 28'h0000000, 0, 0, 1'b0);
        run_op("extreme", 28'h0000007, 0, 28'h7654321, 255, 0, 1'b0);
        run_op("bp", 28'h0456789, 40, 28'h0123456, 37, 5, 1'b1);

        // Asynchronous reset two cycles into a 5-digit shift.
        @(negedge clk);
        a_man = 28'h1234567; a_exp = 8'd15; b_man = 28'h7654321; b_exp = 8'd10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check_outs("midrst", '0, '0, 0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.after_ready", 64'(in_ready), 64'd1);
        run_op("after_rst", 28'h0000567, 6, 28'h0008888, 8, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] am, bm;
            int ae, be;
            am = W'($urandom);
            bm = W'($urandom);
            if (n % 4 == 0) bm = bm & 28'h000F0F0;
            ae = $urandom_range(0, 12);
            be = $urandom_range(0, 12);
            if (n % 7 == 3) ae = $urandom_range(0, 255);
            run_op($sformatf("rnd%0d", n), am, ae, bm, be, $urandom_range(0, 2), n[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
